// File: rtl/corona_stream_gen.sv
// CORONA stimulus transmitter: pseudo-random filler letters with the keyword "CORONA"
// inserted NUM_WORDS times, presented on a ready/valid character stream.
module corona_stream_gen #(
   parameter int         GAP_LEN   = 5,
   parameter int         NUM_WORDS = 3,
   parameter logic [6:0] LFSR_SEED = 7'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ready,
   output logic [6:0] char_out,
   output logic       char_valid,
   output logic       word_end,
   output logic       busy,
   output logic       done
);

   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WORD, DONE} state_t;

   state_t          state_reg;
   logic [6:0]      lfsr_reg;
   logic [6:0]      lfsr_next;
   logic [GW-1:0]   gap_cnt_reg;
   logic [WW-1:0]   word_cnt_reg;
   logic [2:0]      kw_idx_reg;
   logic [6:0]      char_reg;
   logic            valid_reg;
   logic            word_end_reg;
   logic            busy_reg;
   logic            done_reg;

   // 'C' is swapped for 'X' so filler can never begin or extend a false keyword match.
   function automatic logic [6:0] filler_char(input logic [6:0] l);
      logic [4:0] v;
      logic [6:0] c;
      v = l[4:0];
      if (v >= 5'd26)
         v = v - 5'd26;
      c = 7'h41 + {2'b00, v};
      if (c == 7'h43)
         c = 7'h58;
      return c;
   endfunction

   function automatic logic [6:0] kw_char(input logic [2:0] idx);
      case (idx)
         3'd0:    return 7'h43;
         3'd1:    return 7'h4F;
         3'd2:    return 7'h52;
         3'd3:    return 7'h4F;
         3'd4:    return 7'h4E;
         default: return 7'h41;
      endcase
   endfunction

   // Fibonacci LFSR, taps for x^7 + x^6 + 1
   assign lfsr_next = {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         lfsr_reg     <= LFSR_SEED;
         gap_cnt_reg  <= '0;
         word_cnt_reg <= '0;
         kw_idx_reg   <= '0;
         char_reg     <= '0;
         valid_reg    <= 1'b0;
         word_end_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  valid_reg    <= 1'b1;
                  busy_reg     <= 1'b1;
                  word_cnt_reg <= '0;
                  gap_cnt_reg  <= '0;
                  kw_idx_reg   <= '0;
                  word_end_reg <= 1'b0;
                  if (GAP_LEN > 0) begin
                     state_reg <= FILL;
                     char_reg  <= filler_char(lfsr_reg);
                  end else begin
                     state_reg <= WORD;
                     char_reg  <= kw_char(3'd0);
                  end
               end
            end
            FILL: begin
               if (ready) begin
                  lfsr_reg <= lfsr_next;
                  if (gap_cnt_reg == GAP_LAST) begin
                     state_reg  <= WORD;
                     kw_idx_reg <= '0;
                     char_reg   <= kw_char(3'd0);
                  end else begin
                     gap_cnt_reg <= gap_cnt_reg + 1'b1;
                     char_reg    <= filler_char(lfsr_next);
                  end
               end
            end
            WORD: begin
               if (ready) begin
                  if (kw_idx_reg == 3'd5) begin
                     word_end_reg <= 1'b0;
                     kw_idx_reg   <= '0;
                     gap_cnt_reg  <= '0;
                     if (word_cnt_reg == WORD_LAST) begin
                        state_reg <= DONE;
                        char_reg  <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end else begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                        if (GAP_LEN > 0) begin
                           state_reg <= FILL;
                           char_reg  <= filler_char(lfsr_reg);
                        end else begin
                           char_reg <= kw_char(3'd0);
                        end
                     end
                  end else begin
                     kw_idx_reg   <= kw_idx_reg + 1'b1;
                     char_reg     <= kw_char(kw_idx_reg + 1'b1);
                     word_end_reg <= (kw_idx_reg == 3'd4);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign char_out   = char_reg;
   assign char_valid = valid_reg;
   assign word_end   = word_end_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_corona_stream_gen.sv
// Directed bench for corona_stream_gen: timing, backpressure, reset abort,
// back-to-back keywords and filler alphabet over three parameterisations.
module tb_corona_stream_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b, start_c;
   logic       ready_a, ready_b, ready_c;
   logic [6:0] char_a, char_b, char_c;
   logic       valid_a, valid_b, valid_c;
   logic       wend_a, wend_b, wend_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   int checks   = 0;
   int failures = 0;

   corona_stream_gen #(.GAP_LEN(2), .NUM_WORDS(1), .LFSR_SEED(7'h5A)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .char_out(char_a),
      .char_valid(valid_a), .word_end(wend_a), .busy(busy_a), .done(done_a));

   corona_stream_gen #(.GAP_LEN(0), .NUM_WORDS(2), .LFSR_SEED(7'h5A)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .char_out(char_b),
      .char_valid(valid_b), .word_end(wend_b), .busy(busy_b), .done(done_b));

   corona_stream_gen #(.GAP_LEN(250), .NUM_WORDS(2), .LFSR_SEED(7'h5A)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .ready(ready_c), .char_out(char_c),
      .char_valid(valid_c), .word_end(wend_c), .busy(busy_c), .done(done_c));

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   logic [6:0] run1 [8]  = '{7'h41, 7'h56, 7'h43, 7'h4F, 7'h52, 7'h4F, 7'h4E, 7'h41};
   logic [6:0] kw    [6] = '{7'h43, 7'h4F, 7'h52, 7'h4F, 7'h4E, 7'h41};

   initial begin
      int bad;
      int dcnt;
      int n;
      rst = 1'b1;
      start_a = 0; start_b = 0; start_c = 0;
      ready_a = 1; ready_b = 1; ready_c = 1;
      repeat (2) @(negedge clk);
      check("rst_char", char_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_wend", wend_a, 0);
      rst = 1'b0;
      @(negedge clk);

      // Run 1: two fillers then CORONA, start pulsed mid-run must be ignored
      start_a = 1; @(negedge clk); start_a = 0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("r1_char%0d", i), char_a, run1[i]);
         check($sformatf("r1_valid%0d", i), valid_a, 1);
         check($sformatf("r1_busy%0d", i), busy_a, 1);
         check($sformatf("r1_wend%0d", i), wend_a, (i == 7) ? 1 : 0);
         if (i == 4) start_a = 1;
         if (i == 5) start_a = 0;
         @(negedge clk);
      end
      check("r1_done", done_a, 1);
      check("r1_done_valid", valid_a, 0);
      check("r1_done_busy", busy_a, 0);
      @(negedge clk);
      check("r1_done_once", done_a, 0);
      check("r1_idle_valid", valid_a, 0);

      // Run 2: LFSR continues (L, W), then stall 3 cycles on 'R'
      start_a = 1; @(negedge clk); start_a = 0;
      check("r2_fill0", char_a, 7'h4C); @(negedge clk);
      check("r2_fill1", char_a, 7'h57); @(negedge clk);
      check("r2_c", char_a, 7'h43);     @(negedge clk);
      check("r2_o", char_a, 7'h4F);     @(negedge clk);
      check("r2_r", char_a, 7'h52);
      ready_a = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bp_char%0d", i), char_a, 7'h52);
         check($sformatf("bp_valid%0d", i), valid_a, 1);
      end
      ready_a = 1;
      @(negedge clk);
      check("bp_after", char_a, 7'h4F); @(negedge clk);
      check("r2_n", char_a, 7'h4E);     @(negedge clk);
      check("r2_a", char_a, 7'h41);
      check("r2_wend", wend_a, 1);      @(negedge clk);
      check("r2_done", done_a, 1);
      @(negedge clk);

      // Run 3: reset mid-keyword, then restart from the seed sequence
      start_a = 1; @(negedge clk); start_a = 0;
      repeat (4) @(negedge clk);
      check("ab_busy_pre", busy_a, 1);
      rst = 1; @(negedge clk);
      check("ab_valid", valid_a, 0);
      check("ab_busy", busy_a, 0);
      check("ab_wend", wend_a, 0);
      rst = 0;
      start_a = 1; @(negedge clk); start_a = 0;
      check("ab_fill0", char_a, 7'h41); @(negedge clk);
      check("ab_fill1", char_a, 7'h56);
      n = 0;
      while (!done_a && n < 20) begin @(negedge clk); n++; end
      check("ab_done_seen", done_a, 1);
      @(negedge clk);

      // Back-to-back keywords
      dcnt = 0;
      start_b = 1; @(negedge clk); start_b = 0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("b2b_char%0d", i), char_b, kw[i % 6]);
         check($sformatf("b2b_wend%0d", i), wend_b, (i == 5 || i == 11) ? 1 : 0);
         check($sformatf("b2b_valid%0d", i), valid_b, 1);
         @(negedge clk);
      end
      check("b2b_done", done_b, 1);
      for (int i = 0; i < 5; i++) begin
         if (done_b) dcnt++;
         @(negedge clk);
      end
      check("b2b_done_count", dcnt, 1);

      // 500 filler characters across two gaps
      bad = 0;
      start_c = 1; @(negedge clk); start_c = 0;
      for (int i = 0; i < 512; i++) begin
         if (!valid_c) bad++;
         if (i < 250 || (i >= 256 && i < 506)) begin
            if (char_c < 7'h41 || char_c > 7'h5A || char_c == 7'h43) bad++;
         end
         if (i == 250) check("fill_kw1_c", char_c, 7'h43);
         if (i == 506) check("fill_kw2_c", char_c, 7'h43);
         if (i == 511) begin
            check("fill_last_a", char_c, 7'h41);
            check("fill_last_wend", wend_c, 1);
         end
         @(negedge clk);
      end
      check("fill_bad_count", bad, 0);
      check("fill_done", done_c, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
